apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter NB_REQ, default 2: number of requester ports, range 2..8.
REQ-002 Parameter APB_ADDR_WIDTH, default 32: APB address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32: APB data width.
REQ-004 Parameter TIMEOUT, default 16: maximum ACCESS cycles without pready; 0 disables the timeout.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-006 clk  in  1  the single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  NB_REQ  per-requester command valid.
REQ-009 req_ready  out  NB_REQ  per-requester command accept.
REQ-010 req_addr  in  NB_REQ*APB_ADDR_WIDTH  packed addresses; requester i occupies slice i.
REQ-011 req_wdata  in  NB_REQ*APB_DATA_WIDTH  packed write data.
REQ-012 req_write  in  NB_REQ  1 = write, 0 = read.
REQ-013 rsp_valid  out  NB_REQ  one-cycle completion pulse to the owning requester.
REQ-014 rsp_rdata  out  APB_DATA_WIDTH  shared read data, valid with any rsp_valid bit.
REQ-015 rsp_err  out  1  shared error flag, valid with any rsp_valid bit.
REQ-016 master_paddr, master_pwdata, master_pwrite, master_psel, master_penable  out  APB_ADDR_WIDTH / APB_DATA_WIDTH / 1 / 1 / 1  APB master request signals.
REQ-017 master_prdata, master_pready, master_pslverr  in  APB_DATA_WIDTH / 1 / 1  APB completer response signals.

Function
REQ-018 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-019 In IDLE, when any req_valid bit is high, the block SHALL select one winner by round-robin and drive req_ready high combinationally for the winner only.
- Search starts at (last_grant+1) mod NB_REQ.
- last_grant resets to NB_REQ-1, so requester 0 has highest priority after reset.
REQ-020 A command SHALL be accepted only on req_valid & req_ready.
- On acceptance: latch addr, wdata, write and owner index; update last_grant; move to SETUP.
REQ-021 req_ready SHALL be low in SETUP and ACCESS.
- A requester SHALL hold valid and payload stable until it is accepted; withdrawal before acceptance is allowed.
REQ-022 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then move to ACCESS.
REQ-023 ACCESS SHALL drive psel=1 and penable=1 until master_pready=1.
- On pready: register prdata and pslverr into rsp_rdata and rsp_err; pulse rsp_valid[owner] in the next cycle; return to IDLE.
REQ-024 master_paddr, master_pwdata and master_pwrite SHALL come from the latched command and stay stable from SETUP through the final ACCESS cycle.
REQ-025 With a zero-wait completer, the cycle sequence SHALL be:
- T0: accept
- T1: SETUP
- T2: ACCESS with pready
- T3: rsp_valid
REQ-026 IDLE in cycle T3 MAY accept a new command, giving a back-to-back throughput of one transfer per 3 cycles.
REQ-027 An ACCESS-cycle counter SHALL reset to 0 on entering ACCESS.
- When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without pready: deassert psel and penable next cycle, return to IDLE, pulse rsp_valid[owner] with rsp_err=1 and rsp_rdata=0.
REQ-028 pready arriving in the same cycle as the timeout limit SHALL take priority, giving a normal completion.
REQ-029 rsp_rdata SHALL be captured for both reads and writes.
- On writes, the requester ignores rsp_rdata.
- rsp_rdata and rsp_err hold their value between pulses.
REQ-030 Round-robin SHALL wrap from NB_REQ-1 to 0.
- A lone active requester SHALL be granted on every IDLE visit.

Reset
REQ-031 While rst_n=0 at a rising edge, the FSM SHALL enter IDLE and last_grant SHALL be NB_REQ-1.
- Outputs: psel=0, penable=0, paddr=0, pwdata=0, pwrite=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer silently.
- psel=0 next cycle; no rsp_valid is generated for the aborted command.

Verification
REQ-033 Zero-wait read: req0 addr 0x1A10_1000, prdata 0xDEAD_BEEF, pready tied 1 -> ready at T0, SETUP T1, ACCESS T2, rsp_valid[0] at T3 with rdata 0xDEAD_BEEF and err=0.
REQ-034 Contention: req0 and req1 both held valid after reset -> grant order 0,1,0,1, each exactly 3 cycles apart.
REQ-035 Wait states and error: write to 0x1A10_3000, pready after 3 ACCESS cycles with pslverr=1 -> penable high for 3 cycles, paddr/pwdata stable, rsp_err=1.
REQ-036 Timeout: TIMEOUT=4, pready held 0 -> psel drops after 4 ACCESS cycles and rsp_valid arrives with err=1, rdata=0.
- Same test with pready rising in ACCESS cycle 4 -> normal completion, err follows pslverr.
REQ-037 Reset mid-ACCESS: rst_n=0 for one cycle during wait states -> psel=0 next cycle, no rsp_valid, and the next grant goes to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter funnelling NB_REQ command ports onto one APB master.
// Three-phase IDLE/SETUP/ACCESS sequencer with optional ACCESS timeout.
module apb_master_arbiter #(
   parameter int NB_REQ         = 2,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT        = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NB_REQ-1:0]                  req_valid,
   output logic [NB_REQ-1:0]                  req_ready,
   input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
   input  logic [NB_REQ-1:0]                  req_write,
   output logic [NB_REQ-1:0]                  rsp_valid,
   output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
   output logic                               rsp_err,
   output logic [APB_ADDR_WIDTH-1:0]          master_paddr,
   output logic [APB_DATA_WIDTH-1:0]          master_pwdata,
   output logic                               master_pwrite,
   output logic                               master_psel,
   output logic                               master_penable,
   input  logic [APB_DATA_WIDTH-1:0]          master_prdata,
   input  logic                               master_pready,
   input  logic                               master_pslverr
);

   localparam int AW = APB_ADDR_WIDTH;
   localparam int DW = APB_DATA_WIDTH;
   localparam int IW = $clog2(NB_REQ);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t        state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] owner;
   logic [CW-1:0] cnt;

   logic [IW-1:0] win;
   logic [IW-1:0] win_hi;
   logic [IW-1:0] win_lo;
   logic          found_hi;
   logic          found_any;
   logic          accept;
   logic          tmo_hit;

   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_write;

   // Lowest valid index above last_grant wins; otherwise wrap to lowest valid.
   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      win_hi    = '0;
      win_lo    = '0;
      for (int i = NB_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found_any = 1'b1;
            win_lo    = IW'(i);
            if (IW'(i) > last_grant) begin
               found_hi = 1'b1;
               win_hi   = IW'(i);
            end
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   assign accept = (state == IDLE) && found_any;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         req_ready[i] = accept && (IW'(i) == win);
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (IW'(i) == win) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            sel_write = req_write[i];
         end
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         last_grant     <= IW'(NB_REQ - 1);
         owner          <= '0;
         cnt            <= '0;
         master_paddr   <= '0;
         master_pwdata  <= '0;
         master_pwrite  <= 1'b0;
         master_psel    <= 1'b0;
         master_penable <= 1'b0;
         rsp_valid      <= '0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
      end else begin
         rsp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  master_paddr  <= sel_addr;
                  master_pwdata <= sel_wdata;
                  master_pwrite <= sel_write;
                  master_psel   <= 1'b1;
                  owner         <= win;
                  last_grant    <= win;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               master_penable <= 1'b1;
               cnt            <= '0;
               state          <= ACCESS;
            end
            ACCESS: begin
               // pready outranks a timeout landing in the same cycle
               if (master_pready) begin
                  master_psel      <= 1'b0;
                  master_penable   <= 1'b0;
                  rsp_rdata        <= master_prdata;
                  rsp_err          <= master_pslverr;
                  rsp_valid[owner] <= 1'b1;
                  state            <= IDLE;
               end else if (tmo_hit) begin
                  master_psel      <= 1'b0;
                  master_penable   <= 1'b0;
                  rsp_rdata        <= '0;
                  rsp_err          <= 1'b1;
                  rsp_valid[owner] <= 1'b1;
                  state            <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_apb_master_arbiter;

   localparam int NB = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic             clk;
   logic             rst_n;
   logic [NB-1:0]    req_valid;
   logic [NB-1:0]    req_ready;
   logic [NB*AW-1:0] req_addr;
   logic [NB*DW-1:0] req_wdata;
   logic [NB-1:0]    req_write;
   logic [NB-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic [AW-1:0]    master_paddr;
   logic [DW-1:0]    master_pwdata;
   logic             master_pwrite;
   logic             master_psel;
   logic             master_penable;
   logic [DW-1:0]    master_prdata;
   logic             master_pready;
   logic             master_pslverr;

   apb_master_arbiter #(
      .NB_REQ(NB),
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_write(req_write),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .master_paddr(master_paddr),
      .master_pwdata(master_pwdata),
      .master_pwrite(master_pwrite),
      .master_psel(master_psel),
      .master_penable(master_penable),
      .master_prdata(master_prdata),
      .master_pready(master_pready),
      .master_pslverr(master_pslverr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NB-1:0] v, input int last);
      for (int k = 1; k <= NB; k++) begin
         int idx;
         idx = (last + k) % NB;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Reference model: a transfer is "busy" from accept until it retires;
   // age counts cycles since accept (1 = setup, 2.. = access cycles).
   bit            m_ok = 0;
   bit            m_busy;
   int            m_age;
   int            m_last;
   int            m_owner;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_write;
   logic [NB-1:0] m_rsp;
   logic [NB-1:0] m_acc;
   logic [DW-1:0] m_rdata;
   logic          m_err;

   always @(posedge clk) begin
      int w;
      int k;
      if (!rst_n) begin
         m_ok    = 1;
         m_busy  = 0;
         m_age   = 0;
         m_last  = NB - 1;
         m_owner = 0;
         m_addr  = '0;
         m_wdata = '0;
         m_write = 1'b0;
         m_rsp   = '0;
         m_acc   = '0;
         m_rdata = '0;
         m_err   = 1'b0;
      end else begin
         m_rsp = '0;
         m_acc = '0;
         if (!m_busy) begin
            w = rr_pick(req_valid, m_last);
            if (w >= 0) begin
               m_addr   = req_addr[w*AW +: AW];
               m_wdata  = req_wdata[w*DW +: DW];
               m_write  = req_write[w];
               m_owner  = w;
               m_last   = w;
               m_acc[w] = 1'b1;
               m_busy   = 1;
               m_age    = 1;
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else begin
            k = m_age - 1;
            if (master_pready) begin
               m_busy         = 0;
               m_rdata        = master_prdata;
               m_err          = master_pslverr;
               m_rsp[m_owner] = 1'b1;
            end else if (TO != 0 && k == TO) begin
               m_busy         = 0;
               m_rdata        = '0;
               m_err          = 1'b1;
               m_rsp[m_owner] = 1'b1;
            end else begin
               m_age++;
            end
         end
      end
   end

   always @(negedge clk) begin
      int w;
      logic [NB-1:0] exp_ready;
      #2;
      if (m_ok) begin
         w = rr_pick(req_valid, m_last);
         exp_ready = '0;
         if (!m_busy && w >= 0) exp_ready[w] = 1'b1;
         chk("req_ready", req_ready, exp_ready);
         chk("psel", master_psel, m_busy);
         chk("penable", master_penable, m_busy && m_age >= 2);
         chk("paddr", master_paddr, m_addr);
         chk("pwdata", master_pwdata, m_wdata);
         chk("pwrite", master_pwrite, m_write);
         chk("rsp_valid", rsp_valid, m_rsp);
         chk("rsp_rdata", rsp_rdata, m_rdata);
         chk("rsp_err", rsp_err, m_err);
      end
   end

   initial begin
      int pen_n;
      int g_idx[$];
      int g_t[$];
      int mode;
      logic [NB-1:0] nv;

      rst_n          = 1'b0;
      req_valid      = '0;
      req_addr       = '0;
      req_wdata      = '0;
      req_write      = '0;
      master_prdata  = '0;
      master_pready  = 1'b0;
      master_pslverr = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      chk("rst_psel", master_psel, 0);
      chk("rst_penable", master_penable, 0);
      chk("rst_paddr", master_paddr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);

      // zero-wait read from requester 0
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 3'b001;
      req_addr[0 +: AW] = 32'h1A10_1000;
      req_write = '0;
      master_pready = 1'b1;
      master_prdata = 32'hDEAD_BEEF;
      #3 chk("zw_t0_ready", req_ready, 3'b001);
      @(negedge clk);
      req_valid = '0;
      #3 chk("zw_t1_setup", {master_psel, master_penable}, 2'b10);
      chk("zw_t1_paddr", master_paddr, 32'h1A10_1000);
      @(negedge clk);
      #3 chk("zw_t2_access", {master_psel, master_penable}, 2'b11);
      @(negedge clk);
      #3 chk("zw_t3_rsp", rsp_valid, 3'b001);
      chk("zw_t3_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("zw_t3_err", rsp_err, 0);

      // contention between requesters 0 and 1 straight after reset
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 3'b011;
      req_addr[AW +: AW] = 32'h1A10_2000;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #3;
         for (int i = 0; i < NB; i++) begin
            if (req_ready[i]) begin
               g_idx.push_back(i);
               g_t.push_back(c);
            end
         end
      end
      chk("rr_count", g_idx.size(), 4);
      for (int k = 0; k < 4 && k < g_idx.size(); k++) begin
         chk("rr_order", g_idx[k], k % 2);
         chk("rr_time", g_t[k], 3 * k);
      end

      // wait states with slave error on a write from requester 1
      @(negedge clk);
      req_valid = 3'b010;
      req_addr[AW +: AW] = 32'h1A10_3000;
      req_wdata[DW +: DW] = 32'hCAFE_F00D;
      req_write = 3'b010;
      master_pready = 1'b0;
      #3 chk("ws_ready", req_ready, 3'b010);
      pen_n = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         req_valid = '0;
         master_pready = (c == 4);
         master_pslverr = (c == 4);
         #3;
         if (master_penable) pen_n++;
         if (c <= 4) begin
            chk("ws_paddr", master_paddr, 32'h1A10_3000);
            chk("ws_pwdata", master_pwdata, 32'hCAFE_F00D);
            chk("ws_pwrite", master_pwrite, 1);
         end
         if (c == 5) begin
            chk("ws_rsp", rsp_valid, 3'b010);
            chk("ws_err", rsp_err, 1);
         end
      end
      chk("ws_penable_cycles", pen_n, 3);

      // timeout with pready held low, requester 2
      @(negedge clk);
      req_write = '0;
      req_valid = 3'b100;
      req_addr[2*AW +: AW] = 32'h1A10_4000;
      master_pready = 1'b0;
      master_pslverr = 1'b0;
      #3 chk("to_ready", req_ready, 3'b100);
      pen_n = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         req_valid = '0;
         #3;
         if (master_penable) pen_n++;
         if (c == 6) begin
            chk("to_psel", master_psel, 0);
            chk("to_rsp", rsp_valid, 3'b100);
            chk("to_err", rsp_err, 1);
            chk("to_rdata", rsp_rdata, 0);
         end
      end
      chk("to_penable_cycles", pen_n, 4);

      // pready in the fourth access cycle wins over the timeout
      @(negedge clk);
      req_valid = 3'b001;
      master_prdata = 32'h1234_5678;
      #3 chk("tl_ready", req_ready, 3'b001);
      pen_n = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         req_valid = '0;
         master_pready = (c == 5);
         #3;
         if (master_penable) pen_n++;
         if (c == 6) begin
            chk("tl_psel", master_psel, 0);
            chk("tl_rsp", rsp_valid, 3'b001);
            chk("tl_err", rsp_err, 0);
            chk("tl_rdata", rsp_rdata, 32'h1234_5678);
         end
      end
      chk("tl_penable_cycles", pen_n, 4);
      master_pready = 1'b0;

      // reset pulse during wait states aborts silently
      @(negedge clk);
      req_valid = 3'b001;
      #3 chk("ra_ready", req_ready, 3'b001);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         req_valid = '0;
         rst_n = (c != 3);
         if (c == 6) req_valid = 3'b011;
         #3;
         if (c >= 4) chk("ra_no_rsp", rsp_valid, 0);
         if (c == 4) chk("ra_psel", {master_psel, master_penable}, 2'b00);
         if (c == 6) chk("ra_next_grant", req_ready, 3'b001);
      end

      // randomized traffic
      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n % 200 == 0) mode = $urandom_range(0, 2);
         rst_n = ($urandom_range(0, 299) != 0);
         nv = req_valid;
         for (int i = 0; i < NB; i++) begin
            if (!req_valid[i] || m_acc[i]) begin
               nv[i] = ($urandom_range(0, 2) == 0);
               req_addr[i*AW +: AW] = $urandom;
               req_wdata[i*DW +: DW] = $urandom;
               req_write[i] = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
               nv[i] = 1'b0;
            end
         end
         req_valid = nv;
         case (mode)
            0:       master_pready = 1'b1;
            1:       master_pready = 1'($urandom_range(0, 1));
            default: master_pready = ($urandom_range(0, 7) == 0);
         endcase
         master_prdata = $urandom;
         master_pslverr = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
